l1_way_fill_demux: RTL and testbench

//  Write-side counterpart of the L1 way-select read mux. Accepts a refill for one
//  of 8 ways, gathers the line from lower memory as BEATS beats, then presents it
//  to the selected way bank with a one-hot write enable.

---
 rtl/l1_way_fill_demux_pkg.sv | 20 ++
 rtl/l1_way_fill_demux_if.sv | 31 +++
 rtl/l1_way_fill_demux_way_dec_3to8.sv | 17 +
 rtl/l1_way_fill_demux.sv | 95 +++++++++
 tb/tb_l1_way_fill_demux.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_way_fill_demux_pkg.sv
// Shared L1 memory-system constants and the line-fill FSM state encoding.
package l1_way_fill_demux_pkg;

  localparam int L1_BLOCK_SIZE = 128;
  localparam int L1_NUM_WAYS   = 8;
  localparam int L1_WAY_SEL_W  = 3;
  localparam int MEM_BEAT_W    = 32;

  typedef enum logic [1:0] {
    FILL_IDLE    = 2'd0,
    FILL_COLLECT = 2'd1,
    FILL_WRITE   = 2'd2,
    FILL_DONE    = 2'd3
  } fill_state_e;

  function automatic int beats_per_line(input int block_w, input int beat_w);
    return block_w / beat_w;
  endfunction

endpackage

// File: rtl/l1_way_fill_demux_if.sv
// Refill request, memory beat and way-array write bundle for the L1 fill path.
interface l1_way_fill_demux_if
  import l1_way_fill_demux_pkg::*;
#(
  parameter int BLOCK_W = L1_BLOCK_SIZE,
  parameter int BEAT_W  = MEM_BEAT_W
);

  logic                    fill_req_valid;
  logic [L1_WAY_SEL_W-1:0] fill_req_way;
  logic                    fill_req_ready;
  logic                    beat_valid;
  logic [BEAT_W-1:0]       beat_data;
  logic                    beat_ready;
  logic                    way_wr_grant;
  logic [L1_NUM_WAYS-1:0]  way_we;
  logic [BLOCK_W-1:0]      way_wdata;
  logic                    fill_done;

  // master = miss handler / memory side, slave = the fill demux
  modport master (
    output fill_req_valid, fill_req_way, beat_valid, beat_data, way_wr_grant,
    input  fill_req_ready, beat_ready, way_we, way_wdata, fill_done
  );

  modport slave (
    input  fill_req_valid, fill_req_way, beat_valid, beat_data, way_wr_grant,
    output fill_req_ready, beat_ready, way_we, way_wdata, fill_done
  );

endinterface

// File: rtl/l1_way_fill_demux_way_dec_3to8.sv
// Way index to one-hot write-enable decoder; the decode dual of the read-mux select.
module l1_way_fill_demux_way_dec_3to8
  import l1_way_fill_demux_pkg::*;
(
  input  logic                    en,
  input  logic [L1_WAY_SEL_W-1:0] sel,
  output logic [L1_NUM_WAYS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/l1_way_fill_demux.sv
// L1 refill write path: latches the target way, gathers a line from memory beats
// and writes it to the selected way bank once the array port is granted.
module l1_way_fill_demux
  import l1_way_fill_demux_pkg::*;
#(
  parameter int BLOCK_W = L1_BLOCK_SIZE,
  parameter int BEAT_W  = MEM_BEAT_W
) (
  input logic                clk,
  input logic                rst_n,
  l1_way_fill_demux_if.slave bus
);

  localparam int               BEATS     = beats_per_line(BLOCK_W, BEAT_W);
  localparam int               CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  fill_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [L1_WAY_SEL_W-1:0] way_q, way_d;
  logic [BLOCK_W-1:0]      wdata_q, wdata_d;
  logic                    req_ready;
  logic                    beat_ready;
  logic                    we_en;
  logic [L1_NUM_WAYS-1:0]  way_we;

  assign req_ready  = rst_n && (state_q == FILL_IDLE);
  assign beat_ready = (state_q == FILL_COLLECT);
  // Read side owns the array port; only write while it hands us the grant.
  assign we_en      = (state_q == FILL_WRITE) && bus.way_wr_grant;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    way_d   = way_q;
    wdata_d = wdata_q;
    case (state_q)
      FILL_IDLE: begin
        if (bus.fill_req_valid && req_ready) begin
          way_d   = bus.fill_req_way;
          state_d = FILL_COLLECT;
        end
      end
      FILL_COLLECT: begin
        if (bus.beat_valid && beat_ready) begin
          wdata_d[cnt_q*BEAT_W +: BEAT_W] = bus.beat_data;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = FILL_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL_WRITE: begin
        if (bus.way_wr_grant) begin
          state_d = FILL_DONE;
        end
      end
      FILL_DONE: begin
        state_d = FILL_IDLE;
      end
      default: begin
        state_d = FILL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL_IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      wdata_q <= wdata_d;
    end
  end

  l1_way_fill_demux_way_dec_3to8 u_way_dec (
    .en     (we_en),
    .sel    (way_q),
    .onehot (way_we)
  );

  assign bus.fill_req_ready = req_ready;
  assign bus.beat_ready     = beat_ready;
  assign bus.way_we         = way_we;
  assign bus.way_wdata      = wdata_q;
  assign bus.fill_done      = (state_q == FILL_DONE);

endmodule

// File: tb/tb_l1_way_fill_demux.sv
// Randomized self-checking bench for l1_way_fill_demux against a line-level reference model.
module tb_l1_way_fill_demux;
  import l1_way_fill_demux_pkg::*;

  localparam int BLOCK_W = L1_BLOCK_SIZE;
  localparam int BEAT_W  = MEM_BEAT_W;
  localparam int BEATS   = BLOCK_W / BEAT_W;

  typedef logic [BLOCK_W-1:0] word_t;
  typedef logic [BEAT_W-1:0]  beat_arr_t [BEATS];
  typedef int                 gap_arr_t  [BEATS];

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int    checks   = 0;
  int    errors   = 0;
  word_t lastLine = '0;

  always #5 clk = ~clk;

  l1_way_fill_demux_if #(.BLOCK_W(BLOCK_W), .BEAT_W(BEAT_W)) bus ();

  l1_way_fill_demux #(.BLOCK_W(BLOCK_W), .BEAT_W(BEAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input word_t actual, input word_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference line: beat 0 lands in the least significant bits
  function automatic word_t refLine(input beat_arr_t b);
    word_t l;
    l = '0;
    for (int i = BEATS - 1; i >= 0; i--) begin
      l = (l << BEAT_W) | word_t'(b[i]);
    end
    return l;
  endfunction

  // The write enable must never select more than one way
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      checkOutput("we_onehot", word_t'($countones(bus.way_we) > 1), '0);
    end
  end

  // While a fill is busy the requester either holds its next request or toggles junk
  task automatic driveBusyReq(input int holdWay);
    if (holdWay >= 0) begin
      bus.fill_req_valid = 1'b1;
      bus.fill_req_way   = 3'(holdWay);
    end else begin
      bus.fill_req_valid = 1'($urandom % 2);
      bus.fill_req_way   = 3'($urandom % 8);
    end
  endtask

  // Idle cycles with junk beats; nothing may be captured and the last line must persist
  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.fill_req_valid = 1'b0;
      bus.beat_valid     = 1'($urandom % 2);
      bus.beat_data      = $urandom;
      bus.way_wr_grant   = 1'($urandom % 2);
      #1;
      checkOutput("idle_req_ready", word_t'(bus.fill_req_ready), 1);
      checkOutput("idle_beat_ready", word_t'(bus.beat_ready), 0);
      checkOutput("idle_we", word_t'(bus.way_we), 0);
      checkOutput("idle_done", word_t'(bus.fill_done), 0);
      checkOutput("idle_wdata_kept", bus.way_wdata, lastLine);
    end
  endtask

  // One complete fill: handshake, beats with gaps, stalled write, done pulse
  task automatic applyStimulus(input int way, input beat_arr_t beats, input gap_arr_t gaps,
                               input int stall, input int holdWay, input bit reqBeatNoise);
    word_t                  line;
    logic [L1_NUM_WAYS-1:0] weExp;
    line  = refLine(beats);
    weExp = L1_NUM_WAYS'(1 << way);

    @(negedge clk);
    bus.fill_req_valid = 1'b1;
    bus.fill_req_way   = 3'(way);
    bus.beat_valid     = reqBeatNoise;
    bus.beat_data      = $urandom;
    bus.way_wr_grant   = 1'($urandom % 2);
    #1;
    checkOutput("req_ready", word_t'(bus.fill_req_ready), 1);
    checkOutput("req_beat_ready", word_t'(bus.beat_ready), 0);
    checkOutput("req_we", word_t'(bus.way_we), 0);

    for (int i = 0; i < BEATS; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk);
        driveBusyReq(holdWay);
        bus.beat_valid   = 1'b0;
        bus.beat_data    = $urandom;
        bus.way_wr_grant = 1'($urandom % 2);
        #1;
        checkOutput("gap_beat_ready", word_t'(bus.beat_ready), 1);
        checkOutput("gap_req_ready", word_t'(bus.fill_req_ready), 0);
        checkOutput("gap_we", word_t'(bus.way_we), 0);
      end
      @(negedge clk);
      driveBusyReq(holdWay);
      bus.beat_valid   = 1'b1;
      bus.beat_data    = beats[i];
      bus.way_wr_grant = 1'($urandom % 2);
      #1;
      checkOutput("beat_ready", word_t'(bus.beat_ready), 1);
      checkOutput("beat_req_ready", word_t'(bus.fill_req_ready), 0);
      checkOutput("beat_we", word_t'(bus.way_we), 0);
    end

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      driveBusyReq(holdWay);
      bus.way_wr_grant = 1'b0;
      bus.beat_valid   = 1'($urandom % 2);
      bus.beat_data    = $urandom;
      #1;
      checkOutput("stall_we", word_t'(bus.way_we), 0);
      checkOutput("stall_wdata", bus.way_wdata, line);
      checkOutput("stall_beat_ready", word_t'(bus.beat_ready), 0);
      checkOutput("stall_done", word_t'(bus.fill_done), 0);
      checkOutput("stall_req_ready", word_t'(bus.fill_req_ready), 0);
    end

    @(negedge clk);
    driveBusyReq(holdWay);
    bus.way_wr_grant = 1'b1;
    bus.beat_valid   = 1'($urandom % 2);
    bus.beat_data    = $urandom;
    #1;
    checkOutput("write_we", word_t'(bus.way_we), word_t'(weExp));
    checkOutput("write_wdata", bus.way_wdata, line);
    checkOutput("write_done", word_t'(bus.fill_done), 0);

    @(negedge clk);
    driveBusyReq(holdWay);
    bus.way_wr_grant = 1'($urandom % 2);
    bus.beat_valid   = 1'($urandom % 2);
    bus.beat_data    = $urandom;
    #1;
    checkOutput("done_pulse", word_t'(bus.fill_done), 1);
    checkOutput("done_we", word_t'(bus.way_we), 0);
    checkOutput("done_wdata", bus.way_wdata, line);
    checkOutput("done_req_ready", word_t'(bus.fill_req_ready), 0);

    lastLine           = line;
    bus.fill_req_valid = (holdWay >= 0);
    bus.beat_valid     = 1'b0;
  endtask

  task automatic randomFill(input int way, input int holdWay);
    beat_arr_t b;
    gap_arr_t  g;
    for (int i = 0; i < BEATS; i++) begin
      b[i] = $urandom;
      g[i] = $urandom_range(0, 2);
    end
    applyStimulus(way, b, g, $urandom_range(0, 3), holdWay, 1'($urandom % 2));
  endtask

  initial begin
    beat_arr_t b;
    gap_arr_t  noGaps;
    gap_arr_t  g;
    int        pending;
    int        w;
    int        h;

    bus.fill_req_valid = 1'b0;
    bus.fill_req_way   = '0;
    bus.beat_valid     = 1'b0;
    bus.beat_data      = '0;
    bus.way_wr_grant   = 1'b0;
    noGaps             = '{0, 0, 0, 0};

    #2 rst_n = 1'b0;
    @(negedge clk);
    bus.way_wr_grant = 1'b1;
    #1;
    checkOutput("rst_we", word_t'(bus.way_we), 0);
    checkOutput("rst_done", word_t'(bus.fill_done), 0);
    checkOutput("rst_wdata", bus.way_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req_ready", word_t'(bus.fill_req_ready), 1);
    checkOutput("post_rst_beat_ready", word_t'(bus.beat_ready), 0);

    $display("[TB] back-to-back fill of way 5");
    b = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    applyStimulus(5, b, noGaps, 0, -1, 1'b0);
    idleCycles(1);
    checkOutput("t1_line", bus.way_wdata, 128'h44444444_33333333_22222222_11111111);

    $display("[TB] grant withheld for 3 cycles");
    applyStimulus(5, b, noGaps, 3, -1, 1'b0);
    idleCycles(1);

    $display("[TB] beats with valid gaps and stray beats");
    b = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    g = '{0, 2, 0, 1};
    idleCycles(2);
    applyStimulus(3, b, g, 1, -1, 1'b1);
    idleCycles(2);

    $display("[TB] request for way 2 held during fill of way 7");
    b = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    applyStimulus(7, b, noGaps, 2, 2, 1'b0);
    b = '{32'h0BADF00D, 32'h76543210, 32'hFEDCBA98, 32'h13579BDF};
    applyStimulus(2, b, g, 0, -1, 1'b0);
    idleCycles(1);

    $display("[TB] reset after two beats");
    @(negedge clk);
    bus.fill_req_valid = 1'b1;
    bus.fill_req_way   = 3'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.fill_req_valid = 1'b0;
      bus.beat_valid     = 1'b1;
      bus.beat_data      = $urandom;
    end
    @(negedge clk);
    bus.beat_valid   = 1'b0;
    bus.way_wr_grant = 1'b1;
    rst_n            = 1'b0;
    #1;
    checkOutput("midrst_we", word_t'(bus.way_we), 0);
    checkOutput("midrst_done", word_t'(bus.fill_done), 0);
    checkOutput("midrst_beat_ready", word_t'(bus.beat_ready), 0);
    checkOutput("midrst_wdata", bus.way_wdata, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    lastLine = '0;
    idleCycles(3);
    for (int i = 0; i < BEATS; i++) begin
      b[i] = $urandom;
    end
    applyStimulus(0, b, noGaps, 0, -1, 1'b0);
    idleCycles(1);

    $display("[TB] sweep ways 0..7");
    for (int way = 0; way < L1_NUM_WAYS; way++) begin
      randomFill(way, -1);
      idleCycles($urandom_range(0, 2));
    end

    $display("[TB] random fills");
    pending = -1;
    for (int k = 0; k < 20; k++) begin
      w = (pending >= 0) ? pending : int'($urandom % 8);
      h = ($urandom % 3 == 0) ? int'($urandom % 8) : -1;
      randomFill(w, h);
      pending = h;
      if (h < 0) begin
        idleCycles($urandom_range(0, 1));
      end
    end
    if (pending >= 0) begin
      randomFill(pending, -1);
    end
    idleCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
